// File: rtl/iob_reg_wr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin register write arbiter.
package iob_reg_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Index width for ptr, lock_id and owner.
    function automatic int unsigned ptr_w(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Saturating idle counter width, able to hold LOCK_MAX.
    function automatic int unsigned cnt_w(input int unsigned lock_max);
        return $clog2(lock_max + 1);
    endfunction

endpackage

// File: rtl/iob_reg_wr_arbiter_if.sv
// Requester bus of the arbiter: per-requester handshake plus shared register view.
interface iob_reg_wr_arbiter_if
    import iob_reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned PtrW = ptr_w(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       data_out;
    logic [PtrW-1:0]         owner;
    logic                    upd;
    logic                    locked;

    modport master (
        output req_valid, req_lock, req_data,
        input  req_ready, data_out, owner, upd, locked
    );

    modport slave (
        input  req_valid, req_lock, req_data,
        output req_ready, data_out, owner, upd, locked
    );
endinterface

// File: rtl/iob_reg_wr_arbiter_reg.sv
// Enabled holding register with async and sync resets to a fixed value.
module iob_reg_wr_arbiter_reg #(
    parameter int unsigned       DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] data_q;

    // Load on enable; either reset restores RST_VAL.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q <= RST_VAL;
        end else if (rst_i) begin
            data_q <= RST_VAL;
        end else if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/iob_reg_wr_arbiter.sv
// Round-robin write arbiter with optional timed lock, sharing one holding register.
module iob_reg_wr_arbiter
    import iob_reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned       N_REQ    = 4,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] RST_VAL  = '0,
    parameter int unsigned       LOCK_MAX = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    iob_reg_wr_arbiter_if.slave bus_io
);
    localparam int unsigned PtrW = ptr_w(N_REQ);
    localparam int unsigned CntW = cnt_w(LOCK_MAX);

    arb_state_e        state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   lock_id_q, lock_id_d;
    logic [CntW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic              upd_q, upd_d;

    logic [N_REQ-1:0]  grant;
    logic              xfer;
    logic [PtrW-1:0]   win_idx;
    logic              win_lock;
    logic [DATA_W-1:0] win_data;
    logic              hit_hi, hit_any;
    logic [PtrW-1:0]   pick_hi, pick_any;

    // Explicit wrap so non-power-of-two N_REQ works.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] idx);
        return (idx == PtrW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Masked priority pick: lowest valid index >= ptr, else lowest valid overall.
    always_comb begin
        hit_hi   = 1'b0;
        hit_any  = 1'b0;
        pick_hi  = '0;
        pick_any = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (bus_io.req_valid[j]) begin
                hit_any  = 1'b1;
                pick_any = PtrW'(j);
                if (j >= int'(ptr_q)) begin
                    hit_hi  = 1'b1;
                    pick_hi = PtrW'(j);
                end
            end
        end
    end

    // Grant selection; nothing is accepted during reset.
    always_comb begin
        grant   = '0;
        xfer    = 1'b0;
        win_idx = '0;
        if (state_q == ST_LOCKED) begin
            win_idx = lock_id_q;
            xfer    = bus_io.req_valid[lock_id_q];
        end else if (hit_hi) begin
            win_idx = pick_hi;
            xfer    = 1'b1;
        end else if (hit_any) begin
            win_idx = pick_any;
            xfer    = 1'b1;
        end
        if (rst_i) begin
            xfer = 1'b0;
        end
        if (xfer) begin
            grant[win_idx] = 1'b1;
        end
    end

    // Winner's word and lock request.
    always_comb begin
        win_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (j == int'(win_idx)) begin
                win_data = bus_io.req_data[j*DATA_W +: DATA_W];
            end
        end
        win_lock = bus_io.req_lock[win_idx];
    end

    // Next-state logic for the IDLE/LOCKED machine and its bookkeeping.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_id_d  = lock_id_q;
        idle_cnt_d = idle_cnt_q;
        owner_d    = owner_q;
        upd_d      = xfer;
        if (xfer) begin
            owner_d = win_idx;
            ptr_d   = ptr_inc(win_idx);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (xfer && win_lock) begin
                    state_d    = ST_LOCKED;
                    lock_id_d  = win_idx;
                    idle_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    idle_cnt_d = '0;
                    if (!win_lock) begin
                        state_d = ST_IDLE;
                    end
                end else if (idle_cnt_q >= CntW'(LOCK_MAX - 1)) begin
                    // Forced release after LOCK_MAX idle cycles.
                    state_d    = ST_IDLE;
                    ptr_d      = ptr_inc(lock_id_q);
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != CntW'(LOCK_MAX)) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            lock_id_q  <= '0;
            idle_cnt_q <= '0;
            owner_q    <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_id_q  <= lock_id_d;
            idle_cnt_q <= idle_cnt_d;
            owner_q    <= owner_d;
            upd_q      <= upd_d;
        end
    end

    logic [DATA_W-1:0] data_q;

    iob_reg_wr_arbiter_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_reg (
        .clk_i  (clk_i),
        .arst_i (1'b0),
        .rst_i  (rst_i),
        .en_i   (xfer),
        .data_i (win_data),
        .data_o (data_q)
    );

    assign bus_io.req_ready = grant;
    assign bus_io.data_out  = data_q;
    assign bus_io.owner     = owner_q;
    assign bus_io.upd       = upd_q;
    assign bus_io.locked    = (state_q == ST_LOCKED);
endmodule

// File: doc/iob_reg_wr_arbiter.md
# iob_reg_wr_arbiter

Round-robin write arbiter that shares a single `iob_reg` holding register among `N_REQ` requesters. Each requester offers a word with a valid/ready handshake. The arbiter grants one requester per cycle and loads the winner's word into the register. An optional lock lets one requester keep the register for a burst, bounded by a timeout. It sits between the Versat configuration/control masters and any shared configuration or status register they all need to write.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 32: register width.
- `RST_VAL`, default 0: register reset value, truncated to `DATA_W`.
- `LOCK_MAX`, default 16: idle cycles allowed in LOCKED before forced release, ≥1.

One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  `N_REQ`  bit i: requester i offers a word.
- `req_lock`  in  `N_REQ`  bit i: request to keep ownership after this transfer.
- `req_data`  in  `N_REQ*DATA_W`  word i at bits [i*DATA_W +: DATA_W].
- `req_ready`  out  `N_REQ`  one-hot or zero grant; combinational from state and `req_valid`.
- `data_out`  out  `DATA_W`  shared register contents.
- `owner`  out  `$clog2(N_REQ)`  index of the last requester written.
- `upd`  out  1  one-cycle pulse the cycle after a transfer (`data_out` is new).
- `locked`  out  1  high while in LOCKED.

## Operation
- A transfer on i occurs when `req_valid[i] & req_ready[i]`. At most one transfer per cycle.
- `req_ready[i]` is high only if `req_valid[i]` is high. Never more than one bit is set.
- **IDLE state:**
  - The grant goes to the first valid requester, scanning from `ptr` upward modulo `N_REQ`.
  - On a transfer by i: `ptr` becomes (i+1) mod `N_REQ`.
  - If `req_lock[i]`=1: go to LOCKED with `lock_id`=i.
- **LOCKED state:**
  - Only `lock_id` may be granted. All other `req_ready` bits are 0.
  - A transfer by `lock_id` with `req_lock`=0 goes to IDLE, and `ptr` becomes (`lock_id`+1) mod `N_REQ`.
  - A transfer with `req_lock`=1 stays in LOCKED and clears `idle_cnt`.
  - Each cycle with no transfer, `idle_cnt` increments. When `idle_cnt` reaches `LOCK_MAX`-1 and that cycle has no transfer, go to IDLE and set `ptr` = (`lock_id`+1) mod `N_REQ`. This is the forced release.
- **Register update:** on a transfer, the register loads the winner's word, `owner` loads i, and `upd` is 1 next cycle.
- **`rst` (highest priority, any state, including mid-lock):**
  - `data_out`=`RST_VAL`, `owner`=0, `upd`=0, `locked`=0.
  - State IDLE, `ptr`=0, `idle_cnt`=0, `lock_id`=0.
  - `req_ready` is 0 during the `rst` cycle, so no transfer is accepted.
- **Width rules:**
  - `ptr` and `lock_id` are `$clog2(N_REQ)` bits. Wrap is explicit, with no reliance on power-of-two `N_REQ`.
  - `idle_cnt` is `$clog2(LOCK_MAX+1)` bits and saturates; it never wraps.
- With `req_valid`=0, no state changes except `idle_cnt` in LOCKED.

## Timing
- `req_ready` has zero-cycle latency from `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Transfer at cycle t gives `data_out`, `owner` and `upd`=1 at t+1. `upd` returns to 0 at t+2 unless another transfer occurs at t+1.
- Back-to-back transfers are allowed every cycle; throughput is 1 word/cycle.
- `locked` is registered. It rises at t+1 after a locking transfer and falls at t+1 after a release or forced timeout.
- Forced release: after the last owner transfer at cycle t, with no further owner transfers, `locked` falls at t+`LOCK_MAX`+1. Another requester can be granted in that same cycle.

## Structure
- Shared header `iob_reg_wr_arbiter.vh`:
  - state encoding localparams `ST_IDLE`=1'b0, `ST_LOCKED`=1'b1;
  - width helpers for `ptr` and `idle_cnt`.
- One sub-module: `iob_reg` instance for `data_out`.
  - `DATA_W`, `RST_VAL` passed through.
  - `arst` tied 0, `rst`=`rst`, `en`=transfer, `data_in`=muxed winner word.
- Arbiter logic, state register, `ptr`, `idle_cnt`, `owner` and `upd` flops live in the top module.
- Round-robin selection is a masked priority pick: first from requests ≥`ptr`, else from all. It is written as a loop, with no submodule.

## Test plan
- **Reset:** assert `rst` 2 cycles with all valid high.
  - `req_ready`=0, `data_out`=`RST_VAL`, `owner`=0, `upd`=0, `locked`=0.
- **Round-robin:** `N_REQ`=4, all four valid every cycle with data 0xA0+i, no lock.
  - Grants go 0,1,2,3,0. `data_out` follows 0xA0, 0xA1, … one cycle later. `upd` stays high.
- **Sparse requests:** only requesters 1 and 3 valid, `ptr`=2.
  - Grant 3, then 1, then 3.
  - Requester 3 dropping valid mid-sequence means requester 1 is granted each cycle.
- **Lock burst:** requester 2 sends 3 words with lock=1,1,0 while requester 0 stays valid.
  - `req_ready[0]`=0 throughout.
  - `locked` high from the cycle after word 1 until the cycle after word 3.
  - Requester 0 is granted the cycle after word 3.
- **Lock timeout:** `LOCK_MAX`=4; requester 1 transfers with lock=1, then idles while requester 0 is valid.
  - `locked` falls exactly 5 cycles after the transfer.
  - Requester 0 is granted in that cycle.
- **Reset mid-lock:** assert `rst` while `locked`=1.
  - Next cycle: IDLE, `ptr`=0, `data_out`=`RST_VAL`.
  - Requester 0 wins if all are valid.
